// File: rtl/softmax_norm_mul_pipe.sv
// softmax_norm_mul_pipe: two-stage lane-parallel exp x reciprocal normaliser with round-half-up and saturation to Q0.W.
// Define SOFTMAX_NORM_SAT_CNT_EN to add o_sat_cnt, a saturating count of consumed beats with any saturated lane.
module softmax_norm_mul_pipe #(
  parameter int BIT_WIDTH = 16,
  parameter int FRAC_A    = 12,
  parameter int NUM_LANES = 4
) (
  input  logic                           i_clk,
  input  logic                           i_rst_n,
  input  logic                           i_valid,
  output logic                           o_ready,
  input  logic [NUM_LANES*BIT_WIDTH-1:0] i_dataA,
  input  logic [BIT_WIDTH-1:0]           i_dataB,
  input  logic                           i_last,
  output logic                           o_valid,
  input  logic                           i_ready,
  output logic [NUM_LANES*BIT_WIDTH-1:0] o_data,
  output logic                           o_last,
  output logic [NUM_LANES-1:0]           o_sat
`ifdef SOFTMAX_NORM_SAT_CNT_EN
  ,
  output logic [15:0]                    o_sat_cnt
`endif
);
  localparam int W  = BIT_WIDTH;
  localparam int N  = NUM_LANES;
  localparam int RW = 2*W - FRAC_A + 1;
  logic                 w_en;
  logic                 r_v1;
  logic                 r_last1;
  logic [2*W-1:0]       r_prod [N];
  logic [2*W-1:0]       w_prod [N];
  logic [RW-1:0]        w_r    [N];
  logic [N*W-1:0]       w_data;
  logic [N-1:0]         w_sat;
  assign w_en    = ~o_valid | i_ready;
  assign o_ready = w_en;
  // negative exp lanes clamp to zero before the multiply
  always_comb begin
    for (int k = 0; k < N; k++) begin
      w_prod[k] = i_dataA[k*W+W-1] ? '0 : {{W{1'b0}}, i_dataA[k*W +: W]} * {{W{1'b0}}, i_dataB};
      w_r[k] = {1'b0, r_prod[k][2*W-1:FRAC_A]} + RW'(r_prod[k][FRAC_A-1]);
      w_sat[k] = |w_r[k][RW-1:W];
      w_data[k*W +: W] = w_sat[k] ? '1 : w_r[k][W-1:0];
    end
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_v1    <= 1'b0;
      r_last1 <= 1'b0;
      r_prod  <= '{default: '0};
      o_valid <= 1'b0;
      o_data  <= '0;
      o_last  <= 1'b0;
      o_sat   <= '0;
    end else if (w_en) begin
      r_v1    <= i_valid;
      o_valid <= r_v1;
      if (i_valid) begin
        r_prod  <= w_prod;
        r_last1 <= i_last;
      end
      if (r_v1) begin
        o_data <= w_data;
        o_sat  <= w_sat;
        o_last <= r_last1;
      end
    end
  end
`ifdef SOFTMAX_NORM_SAT_CNT_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)
      o_sat_cnt <= '0;
    else if (o_valid && i_ready && |o_sat && o_sat_cnt != 16'hFFFF)
      o_sat_cnt <= o_sat_cnt + 16'd1;
  end
`endif
endmodule
